// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-wide subtract-with-borrow slice, reused every RUN cycle.
module sub_digit
    import serial_sub_pkg::*;
#(
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] full;

    // A negative result leaves the extra top bit set, which is exactly the borrow.
    assign full = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
    assign d    = full[DIGIT-1:0];
    assign bout = full[DIGIT];

endmodule

// File: rtl/serial_sub16.sv
// Digit-serial subtractor: diff = {borrow_out, a - b - bin}, LS digit first.
// Optional signed-overflow output compiled in with `define SERIAL_SUB_OVF_EN.
module serial_sub16
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM   = num_digits(WIDTH, DIGIT);
    localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_sub16: DIGIT must divide WIDTH evenly");
        end
    endgenerate

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;
    logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
    logic [WIDTH-1:0]   res_next;
    logic [DIGIT-1:0]   dig_d;
    logic               dig_bout;
    logic               last;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb, b_msb;
`endif

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x    (a_sr[DIGIT-1:0]),
        .y    (b_sr[DIGIT-1:0]),
        .bin  (borrow),
        .d    (dig_d),
        .bout (dig_bout)
    );

    // New digit enters at the MSB end; after NUM shifts the LS digit sits at bit 0.
    assign res_next = WIDTH'({dig_d, res_sr} >> DIGIT);
    assign last     = (cnt == CNT_W'(NUM - 1));

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                if (last) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state <= next_state;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt    <= '0;
                        borrow <= bin;
                    end
                end
                RUN: begin
                    cnt    <= cnt + CNT_W'(1);
                    borrow <= dig_bout;
                    // diff is written only here, so partial results never show.
                    if (last) begin
                        diff <= {dig_bout, res_next};
`ifdef SERIAL_SUB_OVF_EN
                        ovf  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: operand/result shift registers carry no reset; they are always reloaded on acceptance before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_next;
        end
    end

endmodule
